idex_block: RTL and testbench



---
 rtl/idex_block.sv | 144 ++++++++++++++
 tb/tb_idex_block.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/idex_block.sv
// idex_block: instruction decode stage plus the ID/EX pipeline register.
// It decodes the IF/ID instruction and reads the register file with a
// writeback bypass. It resolves branches and jumps in ID, detects load-use
// and branch-operand hazards, and registers operands and control for EX.
module idex_block #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREG     = 32
) (
   input  logic        CLK,
   input  logic        RSTB,
   input  logic        CNTEN,
   input  logic [31:0] IFIDPC,
   input  logic [31:0] IFIDInst,
   input  logic        WBRegWrite,
   input  logic [4:0]  WBWrReg,
   input  logic [31:0] WBData,
   input  logic        EXMEMRegWrite,
   input  logic [4:0]  EXMEMWrReg,
   output logic        PCsel,
   output logic [31:0] JumporBranch,
   output logic        IFFlush,
   output logic        IFIDStall,
   output logic [31:0] IDEXPC,
   output logic [31:0] IDEXRsData,
   output logic [31:0] IDEXRtData,
   output logic [31:0] IDEXImm,
   output logic [4:0]  IDEXRs,
   output logic [4:0]  IDEXRt,
   output logic [4:0]  IDEXRd,
   output logic [8:0]  IDEXCtrl
);

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;
   localparam logic [5:0] OP_ADDI= 6'h08;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;

   // Control vector bit order: RegWrite MemRead MemWrite MemtoReg ALUSrc RegDst Branch ALUOp[1:0]
   localparam int C_REGWRITE = 8;
   localparam int C_MEMREAD  = 7;
   localparam int C_REGDST   = 3;

   logic [31:0] r_rf [NREG];

   logic [5:0]  w_op;
   logic [4:0]  w_rs, w_rt, w_rd, w_idex_dst;
   logic [31:0] w_imm, w_rs_data, w_rt_data, w_br_tgt, w_j_tgt;
   logic [8:0]  w_ctrl;
   logic        w_is_br, w_uses_rt, w_eq, w_take;
   logic        w_load_use, w_br_haz, w_hazard;

   assign w_op  = IFIDInst[31:26];
   assign w_rs  = IFIDInst[25:21];
   assign w_rt  = IFIDInst[20:16];
   assign w_rd  = IFIDInst[15:11];
   assign w_imm = {{16{IFIDInst[15]}}, IFIDInst[15:0]};

   // Main decoder; unknown opcodes become NOPs
   always_comb begin
      w_ctrl = 9'b0;
      case (w_op)
         OP_R:    w_ctrl = 9'b1_0_0_0_0_1_0_10;
         OP_ADDI: w_ctrl = 9'b1_0_0_0_1_0_0_00;
         OP_LW:   w_ctrl = 9'b1_1_0_1_1_0_0_00;
         OP_SW:   w_ctrl = 9'b0_0_1_0_1_0_0_00;
         OP_BEQ,
         OP_BNE:  w_ctrl = 9'b0_0_0_0_0_0_1_01;
         default: w_ctrl = 9'b0;
      endcase
   end

   // Register file reads: r0 is hardwired zero, writeback data bypasses same-cycle writes
   assign w_rs_data = (w_rs == 5'd0) ? 32'h0 :
                      (WBRegWrite && WBWrReg == w_rs) ? WBData : r_rf[w_rs];
   assign w_rt_data = (w_rt == 5'd0) ? 32'h0 :
                      (WBRegWrite && WBWrReg == w_rt) ? WBData : r_rf[w_rt];

   // Hazard detection
   assign w_is_br    = (w_op == OP_BEQ) || (w_op == OP_BNE);
   assign w_uses_rt  = (w_op == OP_R) || (w_op == OP_SW) || w_is_br;
   assign w_idex_dst = IDEXCtrl[C_REGDST] ? IDEXRd : IDEXRt;

   assign w_load_use = IDEXCtrl[C_MEMREAD] && (IDEXRt != 5'd0) &&
                       ((IDEXRt == w_rs) || (w_uses_rt && IDEXRt == w_rt));

   assign w_br_haz = w_is_br &&
      (((w_rs != 5'd0) &&
        ((IDEXCtrl[C_REGWRITE] && w_rs == w_idex_dst) ||
         (EXMEMRegWrite && w_rs == EXMEMWrReg))) ||
       ((w_rt != 5'd0) &&
        ((IDEXCtrl[C_REGWRITE] && w_rt == w_idex_dst) ||
         (EXMEMRegWrite && w_rt == EXMEMWrReg))));

   assign w_hazard = w_load_use || w_br_haz;

   // Branch / jump resolution; a stall suppresses the redirect so the branch retries
   assign w_eq     = (w_rs_data == w_rt_data);
   assign w_br_tgt = IFIDPC + {w_imm[29:0], 2'b00};
   assign w_j_tgt  = {IFIDPC[31:28], IFIDInst[25:0], 2'b00};
   assign w_take   = ((w_op == OP_BEQ) && w_eq) || ((w_op == OP_BNE) && !w_eq) ||
                     (w_op == OP_J);

   assign PCsel        = RSTB && !w_hazard && w_take;
   assign IFFlush      = PCsel;
   assign JumporBranch = PCsel ? ((w_op == OP_J) ? w_j_tgt : w_br_tgt) : 32'h0;
   // Fetch is already frozen when CNTEN is low, so no stall request then
   assign IFIDStall    = RSTB && CNTEN && w_hazard;

   // Register file write port, gated by the pipeline enable
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= 32'h0;
      end else if (CNTEN && WBRegWrite && WBWrReg != 5'd0) begin
         r_rf[WBWrReg] <= WBData;
      end
   end

   // ID/EX pipeline register; a hazard loads a bubble (control cleared)
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         IDEXPC     <= RESET_PC;
         IDEXRsData <= 32'h0;
         IDEXRtData <= 32'h0;
         IDEXImm    <= 32'h0;
         IDEXRs     <= 5'd0;
         IDEXRt     <= 5'd0;
         IDEXRd     <= 5'd0;
         IDEXCtrl   <= 9'b0;
      end else if (CNTEN) begin
         IDEXPC     <= IFIDPC;
         IDEXRsData <= w_rs_data;
         IDEXRtData <= w_rt_data;
         IDEXImm    <= w_imm;
         IDEXRs     <= w_rs;
         IDEXRt     <= w_rt;
         IDEXRd     <= w_rd;
         IDEXCtrl   <= w_hazard ? 9'b0 : w_ctrl;
      end
   end

endmodule

// File: tb/tb_idex_block.sv
// Bench for idex_block: table of decode/hazard/redirect vectors with a queue of
// expected ID/EX contents, then hand-written freeze and reset sequences.
module tb_idex_block;

   logic        CLK = 1'b0;
   logic        RSTB, CNTEN;
   logic [31:0] IFIDPC, IFIDInst;
   logic        WBRegWrite, EXMEMRegWrite;
   logic [4:0]  WBWrReg, EXMEMWrReg;
   logic [31:0] WBData;
   logic        PCsel, IFFlush, IFIDStall;
   logic [31:0] JumporBranch, IDEXPC, IDEXRsData, IDEXRtData, IDEXImm;
   logic [4:0]  IDEXRs, IDEXRt, IDEXRd;
   logic [8:0]  IDEXCtrl;

   idex_block #(.RESET_PC(32'h0000_0000), .NREG(32)) dut (
      .CLK(CLK), .RSTB(RSTB), .CNTEN(CNTEN), .IFIDPC(IFIDPC), .IFIDInst(IFIDInst),
      .WBRegWrite(WBRegWrite), .WBWrReg(WBWrReg), .WBData(WBData),
      .EXMEMRegWrite(EXMEMRegWrite), .EXMEMWrReg(EXMEMWrReg),
      .PCsel(PCsel), .JumporBranch(JumporBranch), .IFFlush(IFFlush), .IFIDStall(IFIDStall),
      .IDEXPC(IDEXPC), .IDEXRsData(IDEXRsData), .IDEXRtData(IDEXRtData), .IDEXImm(IDEXImm),
      .IDEXRs(IDEXRs), .IDEXRt(IDEXRt), .IDEXRd(IDEXRd), .IDEXCtrl(IDEXCtrl)
   );

   always #5 CLK = ~CLK;

   localparam logic [8:0] C_R   = 9'b100001010;
   localparam logic [8:0] C_ADI = 9'b100010000;
   localparam logic [8:0] C_LW  = 9'b110110000;
   localparam logic [8:0] C_BR  = 9'b000000101;

   typedef struct {
      logic [8:0]  ctrl;
      logic [31:0] imm, pc, rsd, rtd;
      logic [4:0]  rs, rt, rd;
   } idex_t;

   typedef struct {
      logic [31:0] inst, pc;
      logic        wbe;
      logic [4:0]  wbr;
      logic [31:0] wbd;
      logic        exe;
      logic [4:0]  exr;
      logic        stall, pcsel;
      logic [31:0] jb;
      idex_t       ex;
   } vec_t;

   int    n_pass = 0;
   int    n_total = 0;
   idex_t sb[$];
   vec_t  tbl[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic vec_t mk(input logic [31:0] inst, pc, input logic wbe,
                               input logic [4:0] wbr, input logic [31:0] wbd,
                               input logic exe, input logic [4:0] exr,
                               input logic stall, pcsel, input logic [31:0] jb,
                               input logic [8:0] ctrl, input logic [31:0] imm,
                               input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd);
      vec_t v;
      v.inst = inst; v.pc = pc; v.wbe = wbe; v.wbr = wbr; v.wbd = wbd;
      v.exe = exe; v.exr = exr; v.stall = stall; v.pcsel = pcsel; v.jb = jb;
      v.ex.ctrl = ctrl; v.ex.imm = imm; v.ex.pc = pc; v.ex.rsd = rsd; v.ex.rtd = rtd;
      v.ex.rs = rs; v.ex.rt = rt; v.ex.rd = rd;
      return v;
   endfunction

   task automatic check_idex(input string tag);
      idex_t e;
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, " ctrl"},  {23'h0, IDEXCtrl}, {23'h0, e.ctrl});
         chk({tag, " imm"},   IDEXImm, e.imm);
         chk({tag, " pc"},    IDEXPC, e.pc);
         chk({tag, " rsdat"}, IDEXRsData, e.rsd);
         chk({tag, " rtdat"}, IDEXRtData, e.rtd);
         chk({tag, " regs"},  {17'h0, IDEXRs, IDEXRt, IDEXRd}, {17'h0, e.rs, e.rt, e.rd});
      end
   endtask

   initial begin
      idex_t hold;
      RSTB = 1'b0; CNTEN = 1'b0; IFIDPC = 32'h1000_0008; IFIDInst = 32'h0800_0040;
      WBRegWrite = 1'b0; WBWrReg = '0; WBData = '0; EXMEMRegWrite = 1'b0; EXMEMWrReg = '0;

      //           inst          pc            wbe wbr wbd            exe exr st  ps  jb             ctrl   imm            rs rt rd  rsd            rtd
      tbl[0]  = mk(32'h2001_0005, 32'h4,        0, 0, 32'h0,          0, 0,  0, 0, 32'h0,         C_ADI, 32'h5,         0, 1, 0,  32'h0,          32'h0);
      tbl[1]  = mk(32'h0040_1820, 32'h8,        1, 2, 32'hDEAD_BEEF,  0, 0,  0, 0, 32'h0,         C_R,   32'h1820,      2, 0, 3,  32'hDEAD_BEEF,  32'h0);
      tbl[2]  = mk(32'h0040_1820, 32'hC,        1, 0, 32'h1234,       0, 0,  0, 0, 32'h0,         C_R,   32'h1820,      2, 0, 3,  32'hDEAD_BEEF,  32'h0);
      tbl[3]  = mk(32'hFC00_0000, 32'h10,       1, 6, 32'h3,          0, 0,  0, 0, 32'h0,         9'h0,  32'h0,         0, 0, 0,  32'h0,          32'h0);
      tbl[4]  = mk(32'hFC00_0000, 32'h14,       1, 7, 32'h3,          0, 0,  0, 0, 32'h0,         9'h0,  32'h0,         0, 0, 0,  32'h0,          32'h0);
      tbl[5]  = mk(32'h10C7_0004, 32'h100,      0, 0, 32'h0,          0, 0,  0, 1, 32'h110,       C_BR,  32'h4,         6, 7, 0,  32'h3,          32'h3);
      tbl[6]  = mk(32'h14C7_0004, 32'h100,      0, 0, 32'h0,          0, 0,  0, 0, 32'h0,         C_BR,  32'h4,         6, 7, 0,  32'h3,          32'h3);
      tbl[7]  = mk(32'h0800_0040, 32'h1000_0008,0, 0, 32'h0,          0, 0,  0, 1, 32'h1000_0100, 9'h0,  32'h40,        0, 0, 0,  32'h0,          32'h0);
      tbl[8]  = mk(32'h1000_FFFF, 32'h4,        0, 0, 32'h0,          0, 0,  0, 1, 32'h0,         C_BR,  32'hFFFF_FFFF, 0, 0, 31, 32'h0,          32'h0);
      tbl[9]  = mk(32'h10C7_0004, 32'h200,      0, 0, 32'h0,          1, 7,  1, 0, 32'h0,         9'h0,  32'h4,         6, 7, 0,  32'h3,          32'h3);
      tbl[10] = mk(32'h10C7_0004, 32'h200,      0, 0, 32'h0,          0, 0,  0, 1, 32'h210,       C_BR,  32'h4,         6, 7, 0,  32'h3,          32'h3);
      tbl[11] = mk(32'h8C24_0000, 32'h300,      0, 0, 32'h0,          0, 0,  0, 0, 32'h0,         C_LW,  32'h0,         1, 4, 0,  32'h0,          32'h0);
      tbl[12] = mk(32'h0084_2820, 32'h304,      0, 0, 32'h0,          0, 0,  1, 0, 32'h0,         9'h0,  32'h2820,      4, 4, 5,  32'h0,          32'h0);
      tbl[13] = mk(32'h0084_2820, 32'h304,      0, 0, 32'h0,          0, 0,  0, 0, 32'h0,         C_R,   32'h2820,      4, 4, 5,  32'h0,          32'h0);
      tbl[14] = mk(32'h10A0_0008, 32'h400,      0, 0, 32'h0,          0, 0,  1, 0, 32'h0,         9'h0,  32'h8,         5, 0, 0,  32'h0,          32'h0);
      tbl[15] = mk(32'h10A0_0008, 32'h400,      0, 0, 32'h0,          0, 0,  0, 1, 32'h420,       C_BR,  32'h8,         5, 0, 0,  32'h0,          32'h0);

      // Reset state, with a jump presented so PCsel would otherwise be high
      #12;
      chk("rst ctrl",  {23'h0, IDEXCtrl}, 32'h0);
      chk("rst pc",    IDEXPC, 32'h0);
      chk("rst rsdat", IDEXRsData, 32'h0);
      chk("rst pcsel", {31'h0, PCsel}, 32'h0);
      chk("rst stall", {31'h0, IFIDStall}, 32'h0);

      @(negedge CLK); RSTB = 1'b1; CNTEN = 1'b1;

      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         IFIDInst = tbl[i].inst; IFIDPC = tbl[i].pc;
         WBRegWrite = tbl[i].wbe; WBWrReg = tbl[i].wbr; WBData = tbl[i].wbd;
         EXMEMRegWrite = tbl[i].exe; EXMEMWrReg = tbl[i].exr;
         sb.push_back(tbl[i].ex);
         #1;
         chk($sformatf("v%0d stall", i), {31'h0, IFIDStall}, {31'h0, tbl[i].stall});
         chk($sformatf("v%0d pcsel", i), {31'h0, PCsel}, {31'h0, tbl[i].pcsel});
         chk($sformatf("v%0d flush", i), {31'h0, IFFlush}, {31'h0, tbl[i].pcsel});
         chk($sformatf("v%0d target", i), JumporBranch, tbl[i].jb);
         @(posedge CLK); #1;
         check_idex($sformatf("v%0d", i));
      end

      // Freeze: CNTEN low for 3 cycles while inputs and writeback change
      hold = tbl[15].ex;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         CNTEN = 1'b0;
         IFIDInst = (k == 0) ? 32'h10C7_0004 : 32'h2001_0005;
         IFIDPC = 32'h600 + 32'(k * 4);
         WBRegWrite = 1'b1; WBWrReg = 5'd6; WBData = 32'hFFFF_FFFF;
         EXMEMRegWrite = 1'b1; EXMEMWrReg = 5'd7;
         sb.push_back(hold);
         #1;
         chk($sformatf("frz%0d stall", k), {31'h0, IFIDStall}, 32'h0);
         @(posedge CLK); #1;
         check_idex($sformatf("frz%0d", k));
      end
      @(negedge CLK);
      CNTEN = 1'b1; WBRegWrite = 1'b0; EXMEMRegWrite = 1'b0;
      IFIDInst = 32'h00C0_1820; IFIDPC = 32'h500;
      @(posedge CLK); #1;
      chk("frz r6 kept", IDEXRsData, 32'h3);
      chk("frz resume ctrl", {23'h0, IDEXCtrl}, {23'h0, C_R});

      // Reset pulse between edges
      @(negedge CLK);
      IFIDInst = 32'h0800_0040; IFIDPC = 32'h1000_0008;
      #2;
      chk("pre-rst pcsel", {31'h0, PCsel}, 32'h1);
      RSTB = 1'b0;
      #1;
      chk("async ctrl",  {23'h0, IDEXCtrl}, 32'h0);
      chk("async pc",    IDEXPC, 32'h0);
      chk("async pcsel", {31'h0, PCsel}, 32'h0);
      chk("async flush", {31'h0, IFFlush}, 32'h0);
      @(negedge CLK);
      RSTB = 1'b1; IFIDInst = 32'h00C0_1820; IFIDPC = 32'h504;
      @(posedge CLK); #1;
      chk("rf cleared", IDEXRsData, 32'h0);
      chk("post-rst pc", IDEXPC, 32'h504);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
